// File: rtl/pa_pkg.sv
// Shared encodings and default field geometry for the protocol_analysis_p frame analyser.
package pa_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_SYNC = 2'b01;
  localparam logic [1:0] ERR_CRC  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int unsigned PA_SYNC_W    = 8;
  localparam int unsigned PA_TYPE_W    = 8;
  localparam int unsigned PA_BODY_W    = 49;
  localparam int unsigned PA_PAYLOAD_W = 41;
  localparam int unsigned PA_CRC_W     = 8;
  localparam int unsigned PA_TRL_W     = 8;
  localparam logic [7:0]  PA_CRC_POLY  = 8'h07;
  localparam logic [7:0]  PA_SYNC_WORD = 8'hA5;

  // Frame is {sync, type, body, crc, trailer}, trailer at the LSB end
  localparam int unsigned PA_CRC_LSB  = PA_TRL_W;
  localparam int unsigned PA_BODY_LSB = PA_CRC_LSB + PA_CRC_W;
  localparam int unsigned PA_TYPE_LSB = PA_BODY_LSB + PA_BODY_W;
  localparam int unsigned PA_SYNC_LSB = PA_TYPE_LSB + PA_TYPE_W;
  localparam int unsigned PA_FRAME_W  = PA_SYNC_LSB + PA_SYNC_W;

endpackage

// File: rtl/pa_crc_step.sv
// Combinational CRC update over up to BITS message bits, MSB first; only the top nbits are consumed.
module pa_crc_step #(
  parameter int unsigned      CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07,
  parameter int unsigned      BITS  = 1,
  localparam int unsigned     NB_W  = $clog2(BITS + 1)
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [BITS-1:0]  data,
  input  logic [NB_W-1:0]  nbits,
  output logic [CRC_W-1:0] crc_c
);

  logic fb;

  always_comb begin
    crc_c = crc;
    fb    = 1'b0;
    for (int i = 0; i < int'(BITS); i++) begin
      if (i < int'(nbits)) begin
        fb    = crc_c[CRC_W-1] ^ data[BITS-1-i];
        crc_c = {crc_c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
    end
  end

endmodule

// File: rtl/protocol_analysis_p.sv
// Frame analyser on the SPI receive path: sync check, multi-bit CRC check, valid/ready payload out.
// Define PA_ERR_CNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module protocol_analysis_p
  import pa_pkg::*;
#(
  parameter int unsigned       SYNC_W       = PA_SYNC_W,
  parameter int unsigned       TYPE_W       = PA_TYPE_W,
  parameter int unsigned       BODY_W       = PA_BODY_W,
  parameter int unsigned       PAYLOAD_W    = PA_PAYLOAD_W,
  parameter int unsigned       CRC_W        = PA_CRC_W,
  parameter int unsigned       TRL_W        = PA_TRL_W,
  parameter logic [CRC_W-1:0]  CRC_POLY     = PA_CRC_POLY,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = PA_SYNC_WORD,
  parameter int unsigned       BITS_PER_CYC = 1
) (
  input  logic                                          sck,
  input  logic                                          rstn,
  input  logic [SYNC_W+TYPE_W+BODY_W+CRC_W+TRL_W-1:0]   datain,
  input  logic                                          vld,
  output logic                                          busy,
  output logic [TYPE_W-1:0]                             ptype,
  output logic [PAYLOAD_W-1:0]                          payload,
  output logic                                          pvld,
  input  logic                                          prdy,
  output logic                                          perr,
  output logic [1:0]                                    err_code,
  output logic [15:0]                                   err_cnt
);

  localparam int unsigned CRC_LSB  = TRL_W;
  localparam int unsigned BODY_LSB = CRC_LSB + CRC_W;
  localparam int unsigned TYPE_LSB = BODY_LSB + BODY_W;
  localparam int unsigned SYNC_LSB = TYPE_LSB + TYPE_W;
  localparam int unsigned MSG_W    = BODY_W + CRC_W;
  localparam int unsigned N_STEPS  = (MSG_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int unsigned REM_BITS = MSG_W - (N_STEPS - 1) * BITS_PER_CYC;
  localparam int unsigned CNT_W    = $clog2(N_STEPS + 1);
  localparam int unsigned NB_W     = $clog2(BITS_PER_CYC + 1);

  logic [1:0]           state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [CRC_W-1:0]     crc_q, crc_nx, crc_step_c;
  logic [MSG_W-1:0]     msg_q, msg_nx;
  logic [SYNC_W-1:0]    sync_q, sync_nx;
  logic [TYPE_W-1:0]    type_q, type_nx, ptype_nx;
  logic [PAYLOAD_W-1:0] pay_q, pay_nx, payload_nx;
  logic                 pvld_nx, perr_nx, busy_nx;
  logic [1:0]           err_code_nx;
  logic [NB_W-1:0]      nbits_c;
  logic                 trl_unused;

  assign trl_unused = ^datain[TRL_W-1:0];

  // The final step only carries the leftover bits at the top of the shift register
  assign nbits_c = (cnt == CNT_W'(N_STEPS - 1)) ? NB_W'(REM_BITS) : NB_W'(BITS_PER_CYC);

  pa_crc_step #(
    .CRC_W (CRC_W),
    .POLY  (CRC_POLY),
    .BITS  (BITS_PER_CYC)
  ) u_crc_step (
    .crc   (crc_q),
    .data  (msg_q[MSG_W-1 -: BITS_PER_CYC]),
    .nbits (nbits_c),
    .crc_c (crc_step_c)
  );

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    crc_nx      = crc_q;
    msg_nx      = msg_q;
    sync_nx     = sync_q;
    type_nx     = type_q;
    pay_nx      = pay_q;
    ptype_nx    = ptype;
    payload_nx  = payload;
    pvld_nx     = pvld;
    perr_nx     = 1'b0;
    err_code_nx = err_code;

    // Overrun first so a CHECK failure below overrides the code
    if (vld && state != ST_IDLE) begin
      perr_nx     = 1'b1;
      err_code_nx = ERR_OVR;
    end

    case (state)
      ST_IDLE: begin
        if (vld) begin
          sync_nx  = datain[SYNC_LSB +: SYNC_W];
          type_nx  = datain[TYPE_LSB +: TYPE_W];
          pay_nx   = datain[BODY_LSB +: PAYLOAD_W];
          msg_nx   = datain[CRC_LSB +: MSG_W];
          crc_nx   = '0;
          cnt_nx   = '0;
          state_nx = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == CNT_W'(N_STEPS)) begin
          state_nx = ST_CHECK;
        end else begin
          crc_nx = crc_step_c;
          msg_nx = msg_q << BITS_PER_CYC;
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (sync_q != SYNC_WORD) begin
          perr_nx     = 1'b1;
          err_code_nx = ERR_SYNC;
          state_nx    = ST_IDLE;
        end else if (crc_q != '0) begin
          perr_nx     = 1'b1;
          err_code_nx = ERR_CRC;
          state_nx    = ST_IDLE;
        end else begin
          ptype_nx   = type_q;
          payload_nx = pay_q;
          pvld_nx    = 1'b1;
          state_nx   = ST_HOLD;
        end
      end
      default: begin
        if (prdy) begin
          pvld_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      end
    endcase

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      crc_q    <= '0;
      msg_q    <= '0;
      sync_q   <= '0;
      type_q   <= '0;
      pay_q    <= '0;
      ptype    <= '0;
      payload  <= '0;
      pvld     <= 1'b0;
      perr     <= 1'b0;
      err_code <= ERR_NONE;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      crc_q    <= crc_nx;
      msg_q    <= msg_nx;
      sync_q   <= sync_nx;
      type_q   <= type_nx;
      pay_q    <= pay_nx;
      ptype    <= ptype_nx;
      payload  <= payload_nx;
      pvld     <= pvld_nx;
      perr     <= perr_nx;
      err_code <= err_code_nx;
      busy     <= busy_nx;
    end
  end

`ifdef PA_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (perr_nx && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_protocol_analysis_p.sv
// Directed bench for protocol_analysis_p: default build plus a BITS_PER_CYC=8 instance.
module tb_protocol_analysis_p;

  localparam int FW = 81;
`ifdef PA_ERR_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic          sck = 1'b0;
  logic          rstn = 1'b0;
  logic [FW-1:0] datain = '0, datain8 = '0;
  logic          vld = 1'b0, vld8 = 1'b0, prdy = 1'b1, sel = 1'b0;
  logic          busy, busy8, pvld, pvld8, perr, perr8;
  logic [7:0]    ptype, ptype8;
  logic [40:0]   payload, payload8;
  logic [1:0]    err_code, err_code8;
  logic [15:0]   err_cnt, err_cnt8;

  int n_chk = 0;
  int n_err = 0;

  always #5 sck = ~sck;

  protocol_analysis_p u_dut (
    .sck(sck), .rstn(rstn), .datain(datain), .vld(vld), .busy(busy), .ptype(ptype),
    .payload(payload), .pvld(pvld), .prdy(prdy), .perr(perr), .err_code(err_code),
    .err_cnt(err_cnt)
  );

  protocol_analysis_p #(.BITS_PER_CYC(8)) u_dut8 (
    .sck(sck), .rstn(rstn), .datain(datain8), .vld(vld8), .busy(busy8), .ptype(ptype8),
    .payload(payload8), .pvld(pvld8), .prdy(prdy), .perr(perr8), .err_code(err_code8),
    .err_cnt(err_cnt8)
  );

  wire        pvld_m     = sel ? pvld8 : pvld;
  wire        perr_m     = sel ? perr8 : perr;
  wire [1:0]  err_code_m = sel ? err_code8 : err_code;
  wire [7:0]  ptype_m    = sel ? ptype8 : ptype;
  wire [40:0] payload_m  = sel ? payload8 : payload;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // Reference CRC-8, MSB first, init 0, no xorout
  function automatic logic [7:0] crc8(input logic [48:0] body);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 48; i >= 0; i--) begin
      fb = c[7] ^ body[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [FW-1:0] mk(input logic [7:0] s, input logic [7:0] t,
                                       input logic [48:0] b, input logic [7:0] c);
    return {s, t, b, c, 8'hEE};
  endfunction

  // Strobe one frame then watch outputs for a bounded number of edges
  task automatic run_frame(input logic sel_i, input logic [FW-1:0] frm, input int budget,
                           output int pv_k, output int pv_n, output int pe_k, output int pe_n,
                           output logic [1:0] code, output logic [7:0] pt, output logic [40:0] pl);
    sel = sel_i;
    if (sel_i) begin datain8 = frm; vld8 = 1'b1; end
    else begin datain = frm; vld = 1'b1; end
    tick();
    vld = 1'b0; vld8 = 1'b0;
    pv_k = -1; pv_n = 0; pe_k = -1; pe_n = 0; code = 2'b00; pt = '0; pl = '0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (pvld_m) begin
        pv_n++;
        if (pv_k < 0) begin pv_k = k; pt = ptype_m; pl = payload_m; end
      end
      if (perr_m) begin
        pe_n++;
        if (pe_k < 0) begin pe_k = k; code = err_code_m; end
      end
    end
  endtask

  int          pv_k, pv_n, pe_k, pe_n, xfers;
  logic [1:0]  code;
  logic [7:0]  pt;
  logic [40:0] pl;
  logic [48:0] b;
  logic [63:0] r;

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_pvld", pvld, 0);
    check("rst_perr", perr, 0);
    check("rst_code", err_code, 0);
    check("rst_ptype", ptype, 0);
    check("rst_payload", payload, 0);
    check("rst_errcnt", err_cnt, 0);
    rstn = 1'b1;
    tick();

    // Good all-zero body
    run_frame(0, mk(8'hA5, 8'h3C, 49'h0, 8'h00), 70, pv_k, pv_n, pe_k, pe_n, code, pt, pl);
    check("t1_pv_edge", 64'(pv_k), 64'd59);
    check("t1_pv_cycles", 64'(pv_n), 64'd1);
    check("t1_ptype", pt, 8'h3C);
    check("t1_payload", pl, 41'h0);
    check("t1_no_perr", 64'(pe_n), 64'd0);

    // Body bit 0 flipped, CRC left at 00
    run_frame(0, mk(8'hA5, 8'h3C, 49'h1, 8'h00), 70, pv_k, pv_n, pe_k, pe_n, code, pt, pl);
    check("t2_pe_edge", 64'(pe_k), 64'd59);
    check("t2_pe_cycles", 64'(pe_n), 64'd1);
    check("t2_code", code, 2'b10);
    check("t2_no_pvld", 64'(pv_n), 64'd0);
    check("t2_ptype_kept", ptype, 8'h3C);
    check("t2_errcnt", err_cnt, 16'(CNT_EN));

    rstn = 1'b0; #2; rstn = 1'b1;
    tick();

    // Bad sync with a correct CRC
    b = 49'h1_2345_6789_ABCD;
    run_frame(0, mk(8'h5A, 8'h11, b, crc8(b)), 70, pv_k, pv_n, pe_k, pe_n, code, pt, pl);
    check("t3_pe_edge", 64'(pe_k), 64'd59);
    check("t3_code", code, 2'b01);
    check("t3_no_pvld", 64'(pv_n), 64'd0);
    check("t3_errcnt", err_cnt, 16'(CNT_EN));

    // Back-pressure with overruns in CALC-free HOLD and at the HOLD->IDLE edge
    prdy = 1'b0; sel = 1'b0;
    b = 49'h0_DEAD_BEEF_1234;
    datain = mk(8'hA5, 8'h81, b, crc8(b)); vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (64) tick();
    check("t4_hold_pvld", pvld, 1);
    check("t4_hold_payload", payload, b[40:0]);
    r = 64'h0_0000_1111_2222;
    datain = mk(8'hA5, 8'h22, r[48:0], crc8(r[48:0])); vld = 1'b1;
    tick();
    vld = 1'b0;
    check("t4_ovr_perr", perr, 1);
    check("t4_ovr_code", err_code, 2'b11);
    check("t4_ovr_pvld", pvld, 1);
    check("t4_ovr_payload", payload, b[40:0]);
    check("t4_ovr_ptype", ptype, 8'h81);
    tick();
    check("t4_ovr_pulse", perr, 0);
    repeat (12) tick();
    prdy = 1'b1; vld = 1'b1;
    xfers = (pvld && prdy) ? 1 : 0;
    tick();
    vld = 1'b0;
    check("t4_pvld_drop", pvld, 0);
    check("t4_edge_ovr", perr, 1);
    check("t4_edge_code", err_code, 2'b11);
    check("t4_busy_idle", busy, 0);
    for (int k = 0; k < 70; k++) begin
      if (pvld && prdy) xfers++;
      tick();
    end
    check("t4_xfers", 64'(xfers), 64'd1);
    check("t4_errcnt", err_cnt, 16'(3 * CNT_EN));

    // Eight-bit-per-cycle instance against the reference CRC
    for (int f = 0; f < 4; f++) begin
      r = {$urandom(), $urandom()};
      b = r[48:0];
      run_frame(1, mk(8'hA5, 8'(f + 8'h40), b, crc8(b)), 14, pv_k, pv_n, pe_k, pe_n, code, pt, pl);
      check("t5_pv_edge", 64'(pv_k), 64'd10);
      check("t5_ptype", pt, 8'(f + 8'h40));
      check("t5_payload", pl, b[40:0]);
      check("t5_no_perr", 64'(pe_n), 64'd0);
    end
    check("t5_busy", busy8, 0);
    check("t5_errcnt", err_cnt8, 0);

    // Reset in the middle of CALC
    sel = 1'b0;
    datain = mk(8'hA5, 8'h77, 49'h0, 8'h00); vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (10) tick();
    check("t6_busy_calc", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_payload", payload, 0);
    check("t6_rst_ptype", ptype, 0);
    check("t6_rst_code", err_code, 0);
    check("t6_rst_errcnt", err_cnt, 0);
    tick();
    rstn = 1'b1;
    b = 49'h1_0F0F_0F0F_0F0F;
    run_frame(0, mk(8'hA5, 8'h5B, b, crc8(b)), 70, pv_k, pv_n, pe_k, pe_n, code, pt, pl);
    check("t6_pv_edge", 64'(pv_k), 64'd59);
    check("t6_payload", pl, b[40:0]);
    check("t6_no_perr", 64'(pe_n), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/protocol_analysis_p.md
Name: protocol_analysis_p

Overview:
Parametrised successor frame analyser on the SPI receive path. Takes a deserialised frame, checks sync header and a bit-serial CRC, then presents type and payload through a valid/ready handshake. Adds sync check, configurable CRC throughput, error reporting and overrun detection. Sits between the SPI shift/deframe stage and the command decoder.

Parameters:
SYNC_W, 8, sync field width (frame MSBs)
TYPE_W, 8, type field width
BODY_W, 49, checked body width (payload region)
PAYLOAD_W, 41, payload output width = BODY_W LSBs; must be <= BODY_W
CRC_W, 8, CRC field width
TRL_W, 8, trailer width, ignored
CRC_POLY, 8'h07, CRC polynomial, implicit top bit, no reflection, init 0, no xorout
SYNC_WORD, 8'hA5, required sync value
BITS_PER_CYC, 1, CRC bits processed per clock, 1..8

Ports:
sck  in  1  clock
rstn  in  1  async active-low reset
datain  in  FRAME_W  frame = {sync, type, body, crc, trailer}, FRAME_W = SYNC_W+TYPE_W+BODY_W+CRC_W+TRL_W
vld  in  1  one-cycle frame strobe
busy  out  1  high whenever state != IDLE
ptype  out  TYPE_W  frame type
payload  out  PAYLOAD_W  body LSBs
pvld  out  1  good frame available
prdy  in  1  consumer ready
perr  out  1  one-cycle error pulse
err_code  out  2  01 sync, 10 CRC, 11 overrun; held until next perr
err_cnt  out  16  saturating error count (macro only)

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0, field registers 0.
- One clock (sck), all flops async reset on rstn falling edge; reset mid-frame aborts and discards the frame.
- States: IDLE, CALC, CHECK, HOLD.
- IDLE: vld=1 latches sync, type, body and crc into shadow registers; CRC reg <- 0; bit counter <- 0; -> CALC.
- CALC: shifts BITS_PER_CYC bits per cycle of {body, crc}, MSB first, through the CRC register. Runs for N = ceil((BODY_W+CRC_W)/BITS_PER_CYC) cycles. The last step processes only the remaining bits. Then -> CHECK.
- CHECK (1 cycle):
  - sync != SYNC_WORD: perr, err_code=01, -> IDLE. Sync error has priority over CRC error.
  - else CRC residue != 0: perr, err_code=10, -> IDLE.
  - else: drive ptype/payload, pvld=1, -> HOLD.
- HOLD: pvld, ptype and payload stay stable until prdy=1. Transfer occurs on the cycle with pvld&&prdy; pvld drops the next cycle; -> IDLE.
- Latency with prdy tied high: pvld rises N+2 edges after the accepting edge. Default N=57, so pvld rises at edge 59.
- Overrun: vld=1 while state != IDLE gives perr, err_code=11. The new frame is discarded and the current frame is unaffected. Overrun coinciding with a CHECK error: the CHECK error code wins, perr is still a single pulse.
- vld in the same cycle HOLD returns to IDLE counts as an overrun. Accept happens only when state is already IDLE.
- Failed frames never assert pvld. Payload registers keep the last good frame.

Optional Feature:
- Macro: PA_ERR_CNT_EN.
- Defined: err_cnt increments on every perr pulse and saturates at 16'hFFFF. Reset to 0 only by rstn.
- Undefined: err_cnt tied to 0; no counter flops.

Decomposition:
- Package pa_pkg holds: err_code localparams (ERR_NONE, ERR_SYNC, ERR_CRC, ERR_OVR), state encoding, and field-offset localparams derived from the widths.
- One sub-module, pa_crc_step: combinational CRC update of BITS_PER_CYC bits with a valid-bit count input. Instantiated inside the CALC datapath.

Test Plan:
- Defaults, sync=A5, type=3C, body=0, crc=00, prdy=1 -> pvld high at edge 59, ptype=3C, payload=0, no perr.
- Same frame with body bit 0 flipped (crc still 00) -> perr pulse, err_code=10, pvld never asserts.
- sync=5A, correct CRC -> perr, err_code=01 (priority over CRC), err_cnt=1 with PA_ERR_CNT_EN.
- Good frame, prdy=0 for 20 cycles, second vld at cycle 65 -> perr err_code=11; pvld and payload held unchanged; single transfer when prdy rises.
- BITS_PER_CYC=8, random good frames vs. model -> N=8, pvld at edge 10, all accepted.
- rstn pulsed low during CALC -> busy=0 and all outputs 0 immediately; next frame processed normally.
